// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: synchronises and filters the raw PS/2 lines, frames bytes,
// and decodes make/break/E0/E1 prefixes into the 11-bit ps2_key event word.
module ps2_key_rx #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 30000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [10:0] ps2_key,
    output logic        err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

    logic [1:0]    clk_sync_q, dat_sync_q;
    logic          filt_q, filt_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    state_t        state_q, state_d;
    logic [3:0]    bitcnt_q, bitcnt_d;
    logic [9:0]    sh_q, sh_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [10:0]   key_q, key_d;
    logic          ext_q, ext_d, rel_q, rel_d;
    logic [2:0]    skip_q, skip_d;
    logic          err_q, err_d;
    logic          clk_s, dat_s, fall_e, byte_vld, clear_pfx;

    assign clk_s   = clk_sync_q[1];
    assign dat_s   = dat_sync_q[1];
    assign ps2_key = key_q;
    assign err     = err_q;

    // Filtered clock only follows the synchronised line after it has held steady.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        fall_e = 1'b0;
        if (clk_s != filt_q) begin
            if (fcnt_q == FW'(FILTER_LEN - 1)) begin
                filt_d = clk_s;
                fall_e = filt_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        bitcnt_d  = bitcnt_q;
        sh_d      = sh_q;
        tcnt_d    = '0;
        byte_vld  = 1'b0;
        err_d     = 1'b0;
        clear_pfx = 1'b0;
        case (state_q)
            IDLE: begin
                bitcnt_d = '0;
                if (fall_e && !dat_s) state_d = SHIFT;
            end
            SHIFT: begin
                if (fall_e) begin
                    sh_d = {dat_s, sh_q[9:1]};
                    if (bitcnt_q == 4'd9) state_d = CHECK;
                    else                  bitcnt_d = bitcnt_q + 1'b1;
                end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
                    err_d     = 1'b1;
                    clear_pfx = 1'b1;
                    state_d   = IDLE;
                    bitcnt_d  = '0;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            CHECK: begin
                state_d  = IDLE;
                bitcnt_d = '0;
                // sh_q[8:0] is data plus parity; sh_q[9] is the stop bit.
                if ((^sh_q[8:0]) && sh_q[9]) begin
                    byte_vld = 1'b1;
                end else begin
                    err_d     = 1'b1;
                    clear_pfx = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        key_d  = key_q;
        ext_d  = ext_q;
        rel_d  = rel_q;
        skip_d = skip_q;
        if (clear_pfx) begin
            ext_d  = 1'b0;
            rel_d  = 1'b0;
            skip_d = '0;
        end else if (byte_vld) begin
            if (skip_q != 3'd0) begin
                skip_d = skip_q - 1'b1;
            end else begin
                case (sh_q[7:0])
                    8'hE0:   ext_d  = 1'b1;
                    8'hF0:   rel_d  = 1'b1;
                    8'hE1:   skip_d = 3'd7;
                    default: begin
                        key_d = {~key_q[10], ~rel_q, ext_q, sh_q[7:0]};
                        ext_d = 1'b0;
                        rel_d = 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        sh_q <= sh_d;
        if (reset) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            filt_q     <= 1'b1;
            fcnt_q     <= '0;
            state_q    <= IDLE;
            bitcnt_q   <= '0;
            tcnt_q     <= '0;
            key_q      <= '0;
            ext_q      <= 1'b0;
            rel_q      <= 1'b0;
            skip_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk};
            dat_sync_q <= {dat_sync_q[0], ps2_data};
            filt_q     <= filt_d;
            fcnt_q     <= fcnt_d;
            state_q    <= state_d;
            bitcnt_q   <= bitcnt_d;
            tcnt_q     <= tcnt_d;
            key_q      <= key_d;
            ext_q      <= ext_d;
            rel_q      <= rel_d;
            skip_q     <= skip_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_ps2_key_rx.sv
// Directed bench for ps2_key_rx: serial PS/2 frames at a scaled bit rate, prefix decoding,
// parity errors, timeout recovery, pause swallowing, clock glitches and mid-frame reset.
module tb_ps2_key_rx;

    localparam int HALF = 40;
    localparam int FILT = 8;
    localparam int TMO  = 1000;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ps2_clk;
    logic        ps2_data;
    logic [10:0] ps2_key;
    logic        err;

    int tests_run = 0;
    int tests_failed = 0;
    int ev_cnt = 0;
    int err_cnt = 0;
    logic [10:0] key_prev = '0;

    ps2_key_rx #(.FILTER_LEN(FILT), .TIMEOUT(TMO)) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .ps2_clk (ps2_clk),
        .ps2_data(ps2_data),
        .ps2_key (ps2_key),
        .err     (err)
    );

    always #5 clk_sys = ~clk_sys;

    always @(negedge clk_sys) begin
        if (!reset) begin
            if (ps2_key !== key_prev) ev_cnt++;
            if (err === 1'b1) err_cnt++;
        end
        key_prev = ps2_key;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic send_bits(input logic [10:0] fr, input int n, input bit glitch);
        for (int i = 0; i < n; i++) begin
            ps2_data = fr[i];
            if (glitch) begin
                cyc(10);
                ps2_clk = 1'b0;
                cyc(3);
                ps2_clk = 1'b1;
                cyc(HALF - 13);
            end else begin
                cyc(HALF);
            end
            ps2_clk = 1'b0;
            cyc(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        cyc(2 * HALF);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_par, input bit glitch);
        logic p;
        p = bad_par ? (^b) : ~(^b);
        send_bits({1'b1, p, b, 1'b0}, 11, glitch);
    endtask

    task automatic clear_counts();
        ev_cnt  = 0;
        err_cnt = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        cyc(5);
        tests_run++;
        if (ps2_key !== 11'h000) begin
            tests_failed++;
            $display("FAIL reset_key: got %h expected %h", ps2_key, 11'h000);
        end
        tests_run++;
        if (err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_err: got %b expected 0", err);
        end
        reset = 1'b0;
        cyc(20);
    endtask

    task automatic test_make();
        clear_counts();
        send_byte(8'h29, 1'b0, 1'b0);
        tests_run++;
        if (ps2_key !== 11'h629) begin
            tests_failed++;
            $display("FAIL make_29: got %h expected %h", ps2_key, 11'h629);
        end
        tests_run++;
        if (err_cnt !== 0 || ev_cnt !== 1) begin
            tests_failed++;
            $display("FAIL make_29_counts: got err=%0d ev=%0d expected err=0 ev=1", err_cnt, ev_cnt);
        end
    endtask

    task automatic test_break();
        clear_counts();
        send_byte(8'hF0, 1'b0, 1'b0);
        tests_run++;
        if (ev_cnt !== 0) begin
            tests_failed++;
            $display("FAIL break_prefix_event: got ev=%0d expected 0", ev_cnt);
        end
        send_byte(8'h29, 1'b0, 1'b0);
        tests_run++;
        if (ps2_key !== 11'h029 || ev_cnt !== 1) begin
            tests_failed++;
            $display("FAIL break_29: got key=%h ev=%0d expected key=%h ev=1", ps2_key, ev_cnt, 11'h029);
        end
    endtask

    task automatic test_extended();
        clear_counts();
        send_byte(8'hE0, 1'b0, 1'b0);
        send_byte(8'h75, 1'b0, 1'b0);
        tests_run++;
        if (ps2_key !== 11'h775) begin
            tests_failed++;
            $display("FAIL ext_make_75: got %h expected %h", ps2_key, 11'h775);
        end
        send_byte(8'hE0, 1'b0, 1'b0);
        send_byte(8'hF0, 1'b0, 1'b0);
        send_byte(8'h75, 1'b0, 1'b0);
        tests_run++;
        if (ps2_key !== 11'h175) begin
            tests_failed++;
            $display("FAIL ext_break_e0f0: got %h expected %h", ps2_key, 11'h175);
        end
        send_byte(8'hF0, 1'b0, 1'b0);
        send_byte(8'hE0, 1'b0, 1'b0);
        send_byte(8'hE0, 1'b0, 1'b0);
        send_byte(8'h75, 1'b0, 1'b0);
        tests_run++;
        if (ps2_key !== 11'h575 || ev_cnt !== 3) begin
            tests_failed++;
            $display("FAIL ext_break_f0e0: got key=%h ev=%0d expected key=%h ev=3", ps2_key, ev_cnt, 11'h575);
        end
    endtask

    task automatic test_parity();
        clear_counts();
        send_byte(8'h1C, 1'b1, 1'b0);
        tests_run++;
        if (ps2_key !== 11'h575 || ev_cnt !== 0) begin
            tests_failed++;
            $display("FAIL parity_key_held: got key=%h ev=%0d expected key=%h ev=0", ps2_key, ev_cnt, 11'h575);
        end
        tests_run++;
        if (err_cnt !== 1) begin
            tests_failed++;
            $display("FAIL parity_err_pulse: got %0d err cycles expected 1", err_cnt);
        end
        clear_counts();
        send_byte(8'hE0, 1'b0, 1'b0);
        send_byte(8'h33, 1'b1, 1'b0);
        send_byte(8'h1C, 1'b0, 1'b0);
        tests_run++;
        if (ps2_key !== 11'h21C || err_cnt !== 1) begin
            tests_failed++;
            $display("FAIL parity_prefix_clear: got key=%h err=%0d expected key=%h err=1", ps2_key, err_cnt, 11'h21C);
        end
    endtask

    task automatic test_timeout();
        clear_counts();
        send_bits({1'b1, 1'b1, 8'h5A, 1'b0}, 5, 1'b0);
        cyc(TMO + 200);
        tests_run++;
        if (err_cnt !== 1 || ev_cnt !== 0) begin
            tests_failed++;
            $display("FAIL timeout_err: got err=%0d ev=%0d expected err=1 ev=0", err_cnt, ev_cnt);
        end
        send_byte(8'h16, 1'b0, 1'b0);
        tests_run++;
        if (ps2_key !== 11'h616) begin
            tests_failed++;
            $display("FAIL timeout_recover: got %h expected %h", ps2_key, 11'h616);
        end
    endtask

    task automatic test_pause();
        logic [7:0] seq [8];
        seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        clear_counts();
        for (int i = 0; i < 8; i++) send_byte(seq[i], 1'b0, 1'b0);
        tests_run++;
        if (ev_cnt !== 0 || err_cnt !== 0 || ps2_key !== 11'h616) begin
            tests_failed++;
            $display("FAIL pause_swallow: got key=%h ev=%0d err=%0d expected key=%h ev=0 err=0", ps2_key, ev_cnt, err_cnt, 11'h616);
        end
        send_byte(8'h29, 1'b0, 1'b0);
        tests_run++;
        if (ps2_key !== 11'h229 || ev_cnt !== 1) begin
            tests_failed++;
            $display("FAIL pause_then_29: got key=%h ev=%0d expected key=%h ev=1", ps2_key, ev_cnt, 11'h229);
        end
    endtask

    task automatic test_glitch();
        clear_counts();
        send_byte(8'h5A, 1'b0, 1'b1);
        tests_run++;
        if (ps2_key !== 11'h65A || ev_cnt !== 1 || err_cnt !== 0) begin
            tests_failed++;
            $display("FAIL glitch_5a: got key=%h ev=%0d err=%0d expected key=%h ev=1 err=0", ps2_key, ev_cnt, err_cnt, 11'h65A);
        end
    endtask

    task automatic test_reset_mid_frame();
        send_bits({1'b1, 1'b1, 8'h29, 1'b0}, 4, 1'b0);
        reset = 1'b1;
        cyc(3);
        tests_run++;
        if (ps2_key !== 11'h000 || err !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_state: got key=%h err=%b expected key=%h err=0", ps2_key, err, 11'h000);
        end
        reset = 1'b0;
        cyc(20);
        clear_counts();
        send_byte(8'h29, 1'b0, 1'b0);
        tests_run++;
        if (ps2_key !== 11'h629 || ev_cnt !== 1 || err_cnt !== 0) begin
            tests_failed++;
            $display("FAIL midreset_next: got key=%h ev=%0d err=%0d expected key=%h ev=1 err=0", ps2_key, ev_cnt, err_cnt, 11'h629);
        end
    endtask

    initial begin
        test_reset();
        test_make();
        test_break();
        test_extended();
        test_parity();
        test_timeout();
        test_pause();
        test_glitch();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
